// File: rtl/reference_stream_ctrl.sv
// rtl/reference_stream_ctrl.sv - read sequencer/streamer from reference_buffer to the correlator input.
// Optional REF_STREAM_LOOP_EN: continuous wrap-around streaming instead of one pass per start.
module reference_stream_ctrl #(
    parameter int BUFFER_LENGTH = 64,
    parameter int INDEX_BITS    = 6,
    parameter int I_BITS        = 12,
    parameter int Q_BITS        = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [INDEX_BITS-1:0] m_axi_raddr,
    input  logic                  s_axi_rready,
    input  logic [I_BITS-1:0]     i,
    input  logic [Q_BITS-1:0]     q,
    input  logic                  s_axi_data_rvalid,
    output logic [I_BITS-1:0]     out_i,
    output logic [Q_BITS-1:0]     out_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int              CW       = INDEX_BITS + 1;
    localparam logic [CW-1:0]   LAST_IDX = CW'(BUFFER_LENGTH - 1);
    localparam logic [CW-1:0]   PASS_LEN = CW'(BUFFER_LENGTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [INDEX_BITS-1:0] r_raddr;
    logic [CW-1:0]         r_issued;
    logic [CW-1:0]         r_ret_cnt;
    logic [1:0]            r_pending;
    logic [I_BITS-1:0]     r_fifo_i    [2];
    logic [Q_BITS-1:0]     r_fifo_q    [2];
    logic                  r_fifo_last [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;

    logic                  w_busy;
    logic [2:0]            w_outstanding;
    logic                  w_req_valid;
    logic                  w_req_fire;
    logic                  w_req_final;
    logic                  w_ret_fire;
    logic                  w_ret_last;
    logic                  w_out_valid;
    logic                  w_pop;
    logic                  w_head_last;
    logic                  w_last_pop;

    // Credit counts both in-flight reads and FIFO entries, so a return always finds space.
    assign w_busy        = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign w_outstanding = {1'b0, r_pending} + {1'b0, r_count};
    assign w_req_valid   = (r_state == S_ISSUE) && (w_outstanding < 3'd2) && (r_issued < PASS_LEN);
    assign w_req_fire    = w_req_valid && s_axi_rready;
    assign w_req_final   = w_req_fire && (r_issued == LAST_IDX);
    assign w_ret_fire    = s_axi_data_rvalid && w_busy && (r_pending != 2'd0);
    assign w_ret_last    = (r_ret_cnt == LAST_IDX);
    assign w_out_valid   = (r_count != 2'd0);
    assign w_pop         = w_out_valid && out_ready;
    assign w_head_last   = r_fifo_last[r_rd_ptr];
    assign w_last_pop    = w_pop && w_head_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_ISSUE;
            end
            S_ISSUE: begin
`ifndef REF_STREAM_LOOP_EN
                if (w_req_final) w_next = S_DRAIN;
`endif
            end
            S_DRAIN: begin
                if (w_last_pop) w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_raddr  <= '0;
            r_issued <= '0;
        end else if ((r_state == S_DRAIN) && w_last_pop) begin
            r_raddr  <= '0;
            r_issued <= '0;
        end else if (w_req_fire) begin
`ifdef REF_STREAM_LOOP_EN
            if (w_req_final) begin
                r_raddr  <= '0;
                r_issued <= '0;
            end else begin
                r_raddr  <= r_raddr + 1'b1;
                r_issued <= r_issued + 1'b1;
            end
`else
            r_raddr  <= r_raddr + 1'b1;
            r_issued <= r_issued + 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= 2'd0;
            r_ret_cnt <= '0;
        end else begin
            r_pending <= r_pending + {1'b0, w_req_fire} - {1'b0, w_ret_fire};
            if (w_ret_fire) begin
                r_ret_cnt <= w_ret_last ? '0 : r_ret_cnt + 1'b1;
            end
        end
    end

    // Two-entry FIFO; head is always registered, so there is no return-to-output bypass.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                r_fifo_i[k]    <= '0;
                r_fifo_q[k]    <= '0;
                r_fifo_last[k] <= 1'b0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_ret_fire) begin
                r_fifo_i[r_wr_ptr]    <= i;
                r_fifo_q[r_wr_ptr]    <= q;
                r_fifo_last[r_wr_ptr] <= w_ret_last;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_ret_fire} - {1'b0, w_pop};
        end
    end

`ifdef REF_STREAM_LOOP_EN
    logic r_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_last_pop;
        end
    end

    assign done = r_done;
`else
    assign done = (r_state == S_DONE);
`endif

    assign m_axi_rvalid = w_req_valid;
    assign m_axi_rready = w_busy;
    assign m_axi_raddr  = r_raddr;
    assign busy         = w_busy;
    assign out_valid    = w_out_valid;
    assign out_i        = r_fifo_i[r_rd_ptr];
    assign out_q        = r_fifo_q[r_rd_ptr];
    assign out_last     = w_out_valid && w_head_last;

endmodule

// File: tb/tb_reference_stream_ctrl.sv
// tb/tb_reference_stream_ctrl.sv - scoreboard bench for reference_stream_ctrl with a 1-cycle buffer model.
module tb_reference_stream_ctrl;

    localparam int BL = 8;
    localparam int IB = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          m_axi_rvalid;
    logic          m_axi_rready;
    logic [IB-1:0] m_axi_raddr;
    logic          s_axi_rready = 1'b1;
    logic [11:0]   i = '0;
    logic [11:0]   q = '0;
    logic          s_axi_data_rvalid = 1'b0;
    logic [11:0]   out_i;
    logic [11:0]   out_q;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic          busy;
    logic          done;

    reference_stream_ctrl #(
        .BUFFER_LENGTH(BL), .INDEX_BITS(IB), .I_BITS(12), .Q_BITS(12)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_raddr(m_axi_raddr),
        .s_axi_rready(s_axi_rready), .i(i), .q(q), .s_axi_data_rvalid(s_axi_data_rvalid),
        .out_i(out_i), .out_q(out_q), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [11:0] tbl_i [BL] = '{12'h005, 12'h7FF, 12'h800, 12'hFFF, 12'h123, 12'hA5A, 12'h001, 12'h3C4};
    logic [11:0] tbl_q [BL] = '{12'hFFE, 12'h000, 12'h555, 12'h7FE, 12'h801, 12'h0F0, 12'hBAD, 12'h246};

    int          n_vec = 0;
    int          n_err = 0;
    logic [24:0] exp_q [$];
    int          n_pop = 0;
    int          n_acc = 0;
    int          n_done = 0;
    logic [IB-1:0] exp_addr = '0;
    int          rdy_mode = 0;
    bit          rand_en = 1'b0;
    int          cyc = 0;
    int          st_cyc = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Buffer model: capture accepted request on negedge, return data one clock later.
    logic          cap_v = 1'b0;
    logic [IB-1:0] cap_a = '0;
    always @(negedge clk) begin
        cap_v = m_axi_rvalid && s_axi_rready && !reset;
        cap_a = m_axi_raddr;
    end

    always begin
        @(posedge clk);
        #1;
        cyc++;
        s_axi_data_rvalid = cap_v && !reset;
        i = cap_v ? tbl_i[cap_a] : 12'h000;
        q = cap_v ? tbl_q[cap_a] : 12'h000;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: begin
                if (cyc - st_cyc < 10)      out_ready = (((cyc - st_cyc) % 2) == 0);
                else if (cyc - st_cyc < 30) out_ready = 1'b0;
                else                        out_ready = 1'b1;
            end
            default: out_ready = 1'b0;
        endcase
        s_axi_rready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: scoreboard pops, stability and credit checks, all sampled on negedge.
    logic        prev_stall = 1'b0;
    logic [24:0] prev_out = '0;
    logic        prev_hold = 1'b0;
    logic [IB-1:0] prev_addr = '0;
    logic        prev_done = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
            prev_hold  = 1'b0;
            prev_done  = 1'b0;
            exp_addr   = '0;
            n_acc      = 0;
            n_pop      = 0;
            exp_q.delete();
        end else begin
            if ((n_acc - n_pop) >= 2) check("credit_rvalid_low", 64'(m_axi_rvalid), 64'd0);
            if (prev_stall) check("out_stable", {out_valid, out_i, out_q, out_last}, {1'b1, prev_out});
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_i, out_q, out_last};
            if (out_valid && out_ready) begin
                n_pop++;
                if (exp_q.size() == 0) check("out_spurious_count", 64'(n_pop), 64'(n_pop - 1));
                else check("out_sample", {out_i, out_q, out_last}, exp_q.pop_front());
            end
            if (prev_hold) check("req_stable", {m_axi_rvalid, m_axi_raddr}, {1'b1, prev_addr});
            prev_hold = m_axi_rvalid && !s_axi_rready;
            prev_addr = m_axi_raddr;
            if (m_axi_rvalid && s_axi_rready) begin
                check("req_addr", 64'(m_axi_raddr), 64'(exp_addr));
                exp_addr = exp_addr + 1'b1;
                n_acc++;
            end
            if (done) begin
                n_done++;
                if (prev_done) check("done_width", 64'(prev_done && done), 64'd0);
            end
            prev_done = done;
        end
    end

    task automatic push_passes(input int n);
        for (int p = 0; p < n; p++)
            for (int a = 0; a < BL; a++)
                exp_q.push_back({tbl_i[a], tbl_q[a], a == BL - 1});
    endtask

    task automatic do_start(input string nm);
        @(posedge clk); #1;
        start = 1'b1;
        st_cyc = cyc;
        check({nm, "_rvalid_before"}, 64'(m_axi_rvalid), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        check({nm, "_first_rvalid"}, 64'(m_axi_rvalid), 64'd1);
    endtask

    task automatic finish_pass(input string nm, input int d0);
        int k;
        for (k = 0; k < 400 && n_done == d0; k++) begin @(negedge clk); #2; end
        check({nm, "_timeout"}, 64'(k < 400), 64'd1);
        repeat (20) begin @(negedge clk); #2; end
        check({nm, "_done_count"}, 64'(n_done - d0), 64'd1);
        check({nm, "_left_over"}, 64'(exp_q.size()), 64'd0);
        check({nm, "_idle"}, {busy, m_axi_raddr, out_valid}, '0);
    endtask

    task automatic check_zero_outputs(input string nm);
        check(nm, {m_axi_rvalid, m_axi_rready, m_axi_raddr, out_valid, out_i, out_q,
                   out_last, busy, done}, '0);
    endtask

    initial begin
        int d0;
        int k;
        #3;
        check_zero_outputs("reset_state");
        repeat (2) @(negedge clk);
        reset = 1'b0;

`ifdef REF_STREAM_LOOP_EN
        push_passes(3);
        d0 = n_done;
        do_start("loop");
        for (k = 0; k < 400 && n_pop < 3 * BL; k++) begin @(negedge clk); #2; end
        check("loop_timeout", 64'(k < 400), 64'd1);
        rdy_mode = 2;
        repeat (4) begin @(negedge clk); #2; end
        check("loop_done_count", 64'(n_done - d0), 64'd3);
        check("loop_left_over", 64'(exp_q.size()), 64'd0);
        check("loop_busy", 64'(busy), 64'd1);
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        check_zero_outputs("loop_reset");
`else
        push_passes(1);
        d0 = n_done;
        do_start("basic");
        finish_pass("basic", d0);

        rdy_mode = 1;
        push_passes(1);
        d0 = n_done;
        do_start("stall");
        finish_pass("stall", d0);
        rdy_mode = 0;

        rand_en = 1'b1;
        push_passes(1);
        d0 = n_done;
        do_start("rready_rand");
        finish_pass("rready_rand", d0);
        rand_en = 1'b0;

        push_passes(1);
        do_start("midreset");
        for (k = 0; k < 400 && n_pop < 3; k++) begin @(negedge clk); #2; end
        check("midreset_timeout", 64'(k < 400), 64'd1);
        reset = 1'b1;
        #1;
        check_zero_outputs("midreset_async");
        @(negedge clk); #2;
        reset = 1'b0;
        push_passes(1);
        d0 = n_done;
        do_start("replay");
        finish_pass("replay", d0);

        push_passes(1);
        d0 = n_done;
        do_start("restart");
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        finish_pass("restart", d0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
